mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the fetch stage (port IF) and the MEM stage
//  (port DM) of the 5-stage core.

---
 rtl/mem_port_arbiter_pkg.sv | 10 +
 rtl/mem_port_arbiter_if.sv | 57 +++++
 rtl/mem_port_arbiter_owner_fifo.sv | 79 +++++++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Package: mem_arb_pkg
// Shared constants for the IF/DM memory port arbiter: requester IDs stored
// in the owner FIFO and the byte-enable pattern used for instruction fetches.
package mem_arb_pkg;

    localparam logic       PORT_IF  = 1'b0;
    localparam logic       PORT_DM  = 1'b1;
    localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Interface: mem_port_arbiter_if
// Bundles the fetch port (if_*), the data port (dm_*), the memory side
// (mem_*) and the sticky error flag of mem_port_arbiter.
//   slave  : arbiter view (takes requests, drives grants/responses/memory)
//   master : environment view (requesters plus memory macro)
// Parameters: AW address width, DW data width (byte enables are DW/8 wide).
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic              if_req_i;
    logic [AW-1:0]     if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DW-1:0]     if_rdata_o;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [AW-1:0]     dm_addr_i;
    logic [DW-1:0]     dm_wdata_i;
    logic [DW/8-1:0]   dm_be_i;
    logic              dm_gnt_o;
    logic              dm_rvalid_o;
    logic [DW-1:0]     dm_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_wdata_o;
    logic [DW/8-1:0]   mem_be_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DW-1:0]     mem_rdata_i;

    logic              err_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output err_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  err_o
    );

endinterface

// File: rtl/mem_port_arbiter_owner_fifo.sv
// Module: arb_owner_fifo
// DEPTH x 1-bit synchronous FIFO recording which port owns each in-flight
// memory request. Head is visible combinationally on pop_id_o.
// Ports: clk, rst_n (async active-low), push_i/push_id_i, pop_i/pop_id_o,
//        full_o, empty_o, count_o.
// Push while full (without pop) and pop while empty are ignored.
module arb_owner_fifo #(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          push_id_i,
    input  logic          pop_i,
    output logic          pop_id_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic          ids_q [DEPTH];
    logic          ids_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        full_o   = (count_q == CW'(DEPTH));
        empty_o  = (count_q == '0);
        count_o  = count_q;
        pop_id_o = ids_q[rd_ptr_q];

        do_pop   = pop_i & ~empty_o;
        // Full + pop frees the head slot this cycle, so a push may land in it.
        do_push  = push_i & (~full_o | do_pop);

        ids_d    = ids_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            ids_d[wr_ptr_q] = push_id_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ids_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ids_q    <= ids_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Module: mem_port_arbiter
// Shares one single-ported unified memory between the fetch port (IF) and
// the data port (DM). Arbitrates combinationally, forwards the winner to the
// memory, tracks in-flight ownership in order and routes each response back
// to its issuing port in the same cycle it arrives.
// Ports:
//   clk    core clock
//   rst_n  asynchronous active-low reset
//   bus    mem_port_arbiter_if.slave: if_*, dm_*, mem_* and err_o
// Parameters: AW, DW, MAX_OUTST (1..4, in-flight limit / owner FIFO depth).
// Configuration: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// DM has fixed priority over IF.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_OUTST = 2
) (
    input logic           clk,
    input logic           rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned CW = $clog2(MAX_OUTST + 1);

    logic            fifo_full, fifo_empty, owner_id;
    logic [CW-1:0]   fifo_count;
    logic            any_req, win_dm, req_ok, accept, pop;

    logic [AW-1:0]   addr_mux;
    logic [DW-1:0]   wdata_mux;
    logic [DW/8-1:0] be_mux;
    logic            we_mux;

    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
    logic            err_q, err_d;

`ifdef MEM_ARB_RR_EN
    logic            last_q, last_d;
`endif

    arb_owner_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_owner_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (accept),
        .push_id_i (win_dm ? PORT_DM : PORT_IF),
        .pop_i     (pop),
        .pop_id_o  (owner_id),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_comb begin
        any_req = bus.if_req_i | bus.dm_req_i;

`ifdef MEM_ARB_RR_EN
        // On a tie the port not accepted last wins; reset value IF lets DM win first.
        win_dm  = bus.dm_req_i & (~bus.if_req_i | (last_q == PORT_IF));
`else
        win_dm  = bus.dm_req_i;
`endif

        // rst_n gating keeps every output low while reset is asserted even if
        // requesters keep their lines up.
        req_ok  = rst_n & ~fifo_full & any_req;
        accept  = req_ok & bus.mem_gnt_i;
        pop     = rst_n & bus.mem_rvalid_i & ~fifo_empty;

        addr_mux  = '0;
        wdata_mux = '0;
        be_mux    = '0;
        we_mux    = 1'b0;
        if (req_ok) begin
            if (win_dm) begin
                addr_mux  = bus.dm_addr_i;
                wdata_mux = bus.dm_wdata_i;
                be_mux    = bus.dm_be_i;
                we_mux    = bus.dm_we_i;
            end else begin
                addr_mux  = bus.if_addr_i;
                be_mux    = {(DW/32){FETCH_BE}};
            end
        end

        bus.mem_req_o   = req_ok;
        bus.mem_we_o    = we_mux;
        bus.mem_addr_o  = addr_mux;
        bus.mem_wdata_o = wdata_mux;
        bus.mem_be_o    = be_mux;

        bus.dm_gnt_o    = req_ok &  win_dm & bus.mem_gnt_i;
        bus.if_gnt_o    = req_ok & ~win_dm & bus.mem_gnt_i;

        // Response data is passed through combinationally and also captured so
        // the port keeps showing its last response when it is not the owner.
        if_rdata_d      = if_rdata_q;
        dm_rdata_d      = dm_rdata_q;
        bus.if_rvalid_o = 1'b0;
        bus.dm_rvalid_o = 1'b0;
        if (pop) begin
            if (owner_id == PORT_DM) begin
                bus.dm_rvalid_o = 1'b1;
                dm_rdata_d      = bus.mem_rdata_i;
            end else begin
                bus.if_rvalid_o = 1'b1;
                if_rdata_d      = bus.mem_rdata_i;
            end
        end
        bus.if_rdata_o  = if_rdata_d;
        bus.dm_rdata_o  = dm_rdata_d;

        err_d     = err_q | (bus.mem_rvalid_i & fifo_empty);
        bus.err_o = err_q;

`ifdef MEM_ARB_RR_EN
        last_d = accept ? win_dm : last_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            err_q      <= err_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_IF;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int unsigned errors;
    int unsigned checks;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(
        .AW        (32),
        .DW        (32),
        .MAX_OUTST (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        bus.if_req_i     = 1'b0;
        bus.if_addr_i    = '0;
        bus.dm_req_i     = 1'b0;
        bus.dm_we_i      = 1'b0;
        bus.dm_addr_i    = '0;
        bus.dm_wdata_i   = '0;
        bus.dm_be_i      = '0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    // Advance past the next active edge; inputs are then changed and outputs
    // sampled well away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        idle();
        rst_n = 1'b0;
        #2;
        check("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        check("rst_gnt", {30'd0, bus.if_gnt_o, bus.dm_gnt_o}, 32'd0);
        check("rst_rvalid", {30'd0, bus.if_rvalid_o, bus.dm_rvalid_o}, 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Lone IF read, response two cycles later.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h100;
        bus.mem_gnt_i = 1'b1;
        #1;
        check("if_gnt", 32'(bus.if_gnt_o), 32'd1);
        check("if_dm_gnt", 32'(bus.dm_gnt_o), 32'd0);
        check("if_mem_req", 32'(bus.mem_req_o), 32'd1);
        check("if_mem_addr", bus.mem_addr_o, 32'h100);
        check("if_mem_be", 32'(bus.mem_be_o), 32'hF);
        check("if_mem_we", 32'(bus.mem_we_o), 32'd0);
        tick();
        bus.if_req_i = 1'b0;
        #1;
        check("if_gnt_once", 32'(bus.if_gnt_o), 32'd0);
        check("if_mem_req_off", 32'(bus.mem_req_o), 32'd0);
        tick();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hDEADBEEF;
        #1;
        check("if_rvalid", 32'(bus.if_rvalid_o), 32'd1);
        check("if_rdata", bus.if_rdata_o, 32'hDEADBEEF);
        check("if_dm_rvalid", 32'(bus.dm_rvalid_o), 32'd0);
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        #1;
        check("if_rvalid_off", 32'(bus.if_rvalid_o), 32'd0);
        check("if_rdata_hold", bus.if_rdata_o, 32'hDEADBEEF);

        // Both ports request every cycle.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h104;
        bus.dm_req_i  = 1'b1;
        bus.dm_addr_i = 32'h300;
        bus.dm_be_i   = 4'hF;
        bus.mem_gnt_i = 1'b1;
        #1;
        check("both1_dm_gnt", 32'(bus.dm_gnt_o), 32'd1);
        check("both1_if_gnt", 32'(bus.if_gnt_o), 32'd0);
        check("both1_addr", bus.mem_addr_o, 32'h300);
        tick();
        #1;
`ifdef MEM_ARB_RR_EN
        check("both2_dm_gnt", 32'(bus.dm_gnt_o), 32'd0);
        check("both2_if_gnt", 32'(bus.if_gnt_o), 32'd1);
        check("both2_addr", bus.mem_addr_o, 32'h104);
`else
        check("both2_dm_gnt", 32'(bus.dm_gnt_o), 32'd1);
        check("both2_if_gnt", 32'(bus.if_gnt_o), 32'd0);
        check("both2_addr", bus.mem_addr_o, 32'h300);
`endif
        tick();
        #1;
        check("full_mem_req", 32'(bus.mem_req_o), 32'd0);
        check("full_gnt", {30'd0, bus.if_gnt_o, bus.dm_gnt_o}, 32'd0);
        tick();
        // Still full this cycle; pop of the first (DM) entry.
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h11111111;
        #1;
        check("pop1_dm_rvalid", 32'(bus.dm_rvalid_o), 32'd1);
        check("pop1_dm_rdata", bus.dm_rdata_o, 32'h11111111);
        check("pop1_if_rvalid", 32'(bus.if_rvalid_o), 32'd0);
        check("pop1_mem_req", 32'(bus.mem_req_o), 32'd0);
        tick();
        bus.mem_rdata_i = 32'h22222222;
        #1;
        check("resume_dm_gnt", 32'(bus.dm_gnt_o), 32'd1);
`ifdef MEM_ARB_RR_EN
        check("pop2_if_rvalid", 32'(bus.if_rvalid_o), 32'd1);
        check("pop2_if_rdata", bus.if_rdata_o, 32'h22222222);
        check("pop2_dm_rdata_hold", bus.dm_rdata_o, 32'h11111111);
`else
        check("pop2_dm_rvalid", 32'(bus.dm_rvalid_o), 32'd1);
        check("pop2_dm_rdata", bus.dm_rdata_o, 32'h22222222);
        check("pop2_if_rdata_hold", bus.if_rdata_o, 32'hDEADBEEF);
`endif
        tick();
        bus.if_req_i    = 1'b0;
        bus.dm_req_i    = 1'b0;
        bus.mem_rdata_i = 32'h33333333;
        #1;
        check("pop3_dm_rvalid", 32'(bus.dm_rvalid_o), 32'd1);
        check("pop3_dm_rdata", bus.dm_rdata_o, 32'h33333333);
        tick();

        // IF response and DM write accept in the same cycle.
        idle();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h108;
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.if_req_i     = 1'b0;
        bus.dm_req_i     = 1'b1;
        bus.dm_we_i      = 1'b1;
        bus.dm_addr_i    = 32'h200;
        bus.dm_wdata_i   = 32'hA5A5A5A5;
        bus.dm_be_i      = 4'h3;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hCAFEF00D;
        #1;
        check("wr_dm_gnt", 32'(bus.dm_gnt_o), 32'd1);
        check("wr_mem_we", 32'(bus.mem_we_o), 32'd1);
        check("wr_mem_addr", bus.mem_addr_o, 32'h200);
        check("wr_mem_wdata", bus.mem_wdata_o, 32'hA5A5A5A5);
        check("wr_mem_be", 32'(bus.mem_be_o), 32'h3);
        check("wr_if_rvalid", 32'(bus.if_rvalid_o), 32'd1);
        check("wr_if_rdata", bus.if_rdata_o, 32'hCAFEF00D);
        tick();
        idle();
        bus.mem_rvalid_i = 1'b1;
        #1;
        check("wr_ack", 32'(bus.dm_rvalid_o), 32'd1);
        check("wr_ack_if", 32'(bus.if_rvalid_o), 32'd0);
        tick();
        idle();

        // Memory stalls a DM write for three cycles.
        bus.dm_req_i   = 1'b1;
        bus.dm_we_i    = 1'b1;
        bus.dm_addr_i  = 32'h204;
        bus.dm_wdata_i = 32'h0BADF00D;
        bus.dm_be_i    = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_mem_req", 32'(bus.mem_req_o), 32'd1);
            check("stall_addr", bus.mem_addr_o, 32'h204);
            check("stall_wdata", bus.mem_wdata_o, 32'h0BADF00D);
            check("stall_dm_gnt", 32'(bus.dm_gnt_o), 32'd0);
            tick();
        end
        bus.mem_gnt_i = 1'b1;
        #1;
        check("stall_accept", 32'(bus.dm_gnt_o), 32'd1);
        tick();
        idle();
        // Exactly one entry was pushed: first rvalid acks, second is dropped.
        bus.mem_rvalid_i = 1'b1;
        #1;
        check("stall_ack", 32'(bus.dm_rvalid_o), 32'd1);
        check("err_before", 32'(bus.err_o), 32'd0);
        tick();
        #1;
        check("drop_dm_rvalid", 32'(bus.dm_rvalid_o), 32'd0);
        check("drop_if_rvalid", 32'(bus.if_rvalid_o), 32'd0);
        tick();
        bus.mem_rvalid_i = 1'b0;
        #1;
        check("err_set", 32'(bus.err_o), 32'd1);
        tick();
        #1;
        check("err_sticky", 32'(bus.err_o), 32'd1);

        // Reset with two requests in flight and requesters still active.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h10C;
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.if_req_i  = 1'b0;
        bus.dm_req_i  = 1'b1;
        bus.dm_we_i   = 1'b0;
        bus.dm_addr_i = 32'h308;
        tick();
        bus.if_req_i     = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h55555555;
        rst_n = 1'b0;
        #1;
        check("mrst_mem_req", 32'(bus.mem_req_o), 32'd0);
        check("mrst_mem_addr", bus.mem_addr_o, 32'd0);
        check("mrst_gnt", {30'd0, bus.if_gnt_o, bus.dm_gnt_o}, 32'd0);
        check("mrst_rvalid", {30'd0, bus.if_rvalid_o, bus.dm_rvalid_o}, 32'd0);
        check("mrst_rdata", bus.if_rdata_o | bus.dm_rdata_o, 32'd0);
        check("mrst_err", 32'(bus.err_o), 32'd0);
        tick();
        idle();
        rst_n = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h66666666;
        #1;
        check("post_rst_rvalid", {30'd0, bus.if_rvalid_o, bus.dm_rvalid_o}, 32'd0);
        tick();
        bus.mem_rvalid_i = 1'b0;
        #1;
        check("post_rst_err", 32'(bus.err_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
